// File: rtl/audio_pkg.sv
// Shared audio types used by the synth engine, the sample FIFO and the I2S transmitter.
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Sent to the transmitter whenever no real sample is available.
  localparam sample_t SILENCE = '0;

endpackage

// File: rtl/sample_fifo_mem.sv
// Simple dual-port register array. It has a synchronous write port and a
// combinational read port, so the read word can be captured on the same edge
// that the read pointer advances.
module sync_fifo_mem #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is not reset; the pointers decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sample_fifo.sv
// Buffer between the synth voice engine and the I2S transmitter. The FIFO is
// popped on every LRCLK edge, so each channel slot gets a fresh word. When the
// FIFO is starved it outputs silence and counts the underrun.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH        = 24,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                   MCLK,
  input  logic                   RESET,
  input  logic [WIDTH-1:0]       WR_DATA,
  input  logic                   WR_EN,
  output logic                   FULL,
  output logic                   ALMOST_FULL,
  output logic [$clog2(DEPTH):0] LEVEL,
  input  logic                   LRCLK,
  input  logic                   FIFO_READ,
  output logic [WIDTH-1:0]       AUDIO,
  output logic                   FIFO_EMPTY,
  output logic [15:0]            UNDERRUN_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // The pointers carry one extra wrap bit, so full and empty are distinct.
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic             lr_q;
  logic [WIDTH-1:0] audio_q, audio_d;
  logic [15:0]      urun_q, urun_d;

  logic [PW-1:0]    level;
  logic             full, empty, wr_fire, pop_req;
  logic [WIDTH-1:0] rd_word;

  assign level   = wp_q - rp_q;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (level == '0);
  // Full is taken from the registered pointers, so a pop in the same cycle
  // does not make room for a write.
  assign wr_fire = WR_EN && !full;
  assign pop_req = (LRCLK != lr_q) && FIFO_READ;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (MCLK),
    .we_i    (wr_fire),
    .waddr_i (wp_q[AW-1:0]),
    .wdata_i (WR_DATA),
    .raddr_i (rp_q[AW-1:0]),
    .rdata_o (rd_word)
  );

  // Next-state for the pointers, the output word and the underrun counter.
  // An empty pop emits silence and never falls through to a word written in
  // the same cycle.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    audio_d = audio_q;
    urun_d  = urun_q;
    if (wr_fire) wp_d = wp_q + PW'(1);
    if (pop_req) begin
      if (!empty) begin
        audio_d = rd_word;
        rp_d    = rp_q + PW'(1);
      end else begin
        audio_d = WIDTH'(SILENCE);
        if (urun_q != 16'hFFFF) urun_d = urun_q + 16'd1;
      end
    end
  end

  // State registers. Reset discards the contents and also masks any LRCLK
  // edge that arrives in the same cycle.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      wp_q    <= '0;
      rp_q    <= '0;
      lr_q    <= 1'b0;
      audio_q <= '0;
      urun_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lr_q    <= LRCLK;
      audio_q <= audio_d;
      urun_q  <= urun_d;
    end
  end

  assign LEVEL          = level;
  assign FULL           = full;
  assign FIFO_EMPTY     = empty;
  assign ALMOST_FULL    = (level >= PW'(AFULL_THRESH));
  assign AUDIO          = audio_q;
  assign UNDERRUN_COUNT = urun_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: a per-cycle vector table plus hand-written
// sequences for fill, underrun, pointer wrap and reset.
module tb_sample_fifo;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic [23:0] WR_DATA;
  logic        WR_EN;
  logic        FULL, ALMOST_FULL;
  logic [4:0]  LEVEL;
  logic        LRCLK;
  logic        FIFO_READ;
  logic [23:0] AUDIO;
  logic        FIFO_EMPTY;
  logic [15:0] UNDERRUN_COUNT;

  int n_vec = 0;
  int n_err = 0;

  sample_fifo #(.WIDTH(24), .DEPTH(16), .AFULL_THRESH(12)) dut (
    .MCLK           (MCLK),
    .RESET          (RESET),
    .WR_DATA        (WR_DATA),
    .WR_EN          (WR_EN),
    .FULL           (FULL),
    .ALMOST_FULL    (ALMOST_FULL),
    .LEVEL          (LEVEL),
    .LRCLK          (LRCLK),
    .FIFO_READ      (FIFO_READ),
    .AUDIO          (AUDIO),
    .FIFO_EMPTY     (FIFO_EMPTY),
    .UNDERRUN_COUNT (UNDERRUN_COUNT)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [23:0] d;
    logic        lr;
    logic        rd;
    logic [4:0]  lvl;
    logic        emp;
    logic [23:0] aud;
    logic [15:0] uc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the clock edge.
  task automatic step(input logic rst, input logic wr, input logic [23:0] d,
                      input logic lr, input logic rd);
    RESET = rst; WR_EN = wr; WR_DATA = d; LRCLK = lr; FIFO_READ = rd;
    @(posedge MCLK);
    #1;
  endtask

  task automatic do_reset(input logic lr);
    step(1'b1, 1'b0, 24'h0, lr, 1'b1);
    step(1'b1, 1'b0, 24'h0, lr, 1'b1);
  endtask

  logic        lr;
  logic [23:0] exp_w;
  int          max_lvl;

  initial begin
    // cycle-by-cycle table starting from reset with LRCLK low
    tbl[0]  = '{1'b1, 24'h000001, 1'b0, 1'b1, 5'd1, 1'b0, 24'h000000, 16'd0};
    tbl[1]  = '{1'b1, 24'h000002, 1'b0, 1'b1, 5'd2, 1'b0, 24'h000000, 16'd0};
    tbl[2]  = '{1'b1, 24'h000003, 1'b0, 1'b1, 5'd3, 1'b0, 24'h000000, 16'd0};
    tbl[3]  = '{1'b1, 24'h000004, 1'b0, 1'b1, 5'd4, 1'b0, 24'h000000, 16'd0};
    tbl[4]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 5'd3, 1'b0, 24'h000001, 16'd0};
    tbl[5]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 5'd3, 1'b0, 24'h000001, 16'd0};
    tbl[6]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 5'd2, 1'b0, 24'h000002, 16'd0};
    tbl[7]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 5'd1, 1'b0, 24'h000003, 16'd0};
    tbl[8]  = '{1'b1, 24'h000005, 1'b0, 1'b1, 5'd1, 1'b0, 24'h000004, 16'd0};
    tbl[9]  = '{1'b0, 24'h000000, 1'b1, 1'b1, 5'd0, 1'b1, 24'h000005, 16'd0};
    tbl[10] = '{1'b0, 24'h000000, 1'b0, 1'b1, 5'd0, 1'b1, 24'h000000, 16'd1};
    tbl[11] = '{1'b0, 24'h000000, 1'b1, 1'b0, 5'd0, 1'b1, 24'h000000, 16'd1};
    tbl[12] = '{1'b1, 24'h000006, 1'b0, 1'b1, 5'd1, 1'b0, 24'h000000, 16'd2};
    tbl[13] = '{1'b0, 24'h000000, 1'b0, 1'b1, 5'd1, 1'b0, 24'h000000, 16'd2};
    tbl[14] = '{1'b0, 24'h000000, 1'b1, 1'b1, 5'd0, 1'b1, 24'h000006, 16'd2};

    // reset state
    do_reset(1'b0);
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    chk("rst_level", LEVEL, 0);
    chk("rst_empty", FIFO_EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_afull", ALMOST_FULL, 0);
    chk("rst_audio", AUDIO, 0);
    chk("rst_urun", UNDERRUN_COUNT, 0);

    // table vectors
    for (int i = 0; i < 15; i++) begin
      step(1'b0, tbl[i].wr, tbl[i].d, tbl[i].lr, tbl[i].rd);
      chk($sformatf("tbl%0d_level", i), LEVEL, tbl[i].lvl);
      chk($sformatf("tbl%0d_empty", i), FIFO_EMPTY, tbl[i].emp);
      chk($sformatf("tbl%0d_audio", i), AUDIO, tbl[i].aud);
      chk($sformatf("tbl%0d_urun", i), UNDERRUN_COUNT, tbl[i].uc);
    end

    // four words popped at half-frame spacing
    do_reset(1'b0);
    lr = 1'b0;
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 24'(i), lr, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      for (int c = 0; c < 127; c++) step(1'b0, 1'b0, 24'h0, lr, 1'b1);
      chk($sformatf("hf%0d_before", i), AUDIO, 24'(i - 1));
      lr = ~lr;
      step(1'b0, 1'b0, 24'h0, lr, 1'b1);
      chk($sformatf("hf%0d_audio", i), AUDIO, 24'(i));
    end
    chk("hf_empty", FIFO_EMPTY, 1);
    chk("hf_urun", UNDERRUN_COUNT, 0);

    // fill to full, 17th write dropped
    do_reset(1'b0);
    lr = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b1, (i == 17) ? 24'hABCDEF : 24'(i), lr, 1'b1);
      chk($sformatf("fill%0d_level", i), LEVEL, (i > 16) ? 16 : i);
      chk($sformatf("fill%0d_afull", i), ALMOST_FULL, (i >= 12) ? 1 : 0);
      chk($sformatf("fill%0d_full", i), FULL, (i >= 16) ? 1 : 0);
    end
    // write while full with a simultaneous pop: write still dropped
    lr = ~lr;
    step(1'b0, 1'b1, 24'h123456, lr, 1'b1);
    chk("fullpop_audio", AUDIO, 24'h1);
    chk("fullpop_level", LEVEL, 15);
    for (int i = 2; i <= 16; i++) begin
      lr = ~lr;
      step(1'b0, 1'b0, 24'h0, lr, 1'b1);
      chk($sformatf("drain%0d", i), AUDIO, 24'(i));
    end
    chk("drain_empty", FIFO_EMPTY, 1);
    lr = ~lr;
    step(1'b0, 1'b0, 24'h0, lr, 1'b1);
    chk("drain_extra_audio", AUDIO, 0);

    // three underruns
    do_reset(1'b0);
    lr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      lr = ~lr;
      step(1'b0, 1'b0, 24'h0, lr, 1'b1);
      step(1'b0, 1'b0, 24'h0, lr, 1'b1);
      chk($sformatf("ur%0d_audio", i), AUDIO, 0);
    end
    chk("ur_count", UNDERRUN_COUNT, 3);

    // 40 write/pop pairs across pointer rollover
    do_reset(1'b0);
    lr = 1'b0;
    max_lvl = 0;
    for (int k = 0; k < 40; k++) begin
      exp_w = 24'h100 + 24'(k * 3);
      step(1'b0, 1'b1, exp_w, lr, 1'b1);
      if (int'(LEVEL) > max_lvl) max_lvl = int'(LEVEL);
      lr = ~lr;
      step(1'b0, 1'b0, 24'h0, lr, 1'b1);
      if (int'(LEVEL) > max_lvl) max_lvl = int'(LEVEL);
      chk($sformatf("wrap%0d", k), AUDIO, exp_w);
    end
    chk("wrap_maxlvl_le2", (max_lvl <= 2) ? 1 : 0, 1);
    chk("wrap_urun", UNDERRUN_COUNT, 0);

    // reset with five words held, LRCLK edge coinciding with reset
    lr = 1'b0;
    step(1'b0, 1'b0, 24'h0, lr, 1'b1);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 24'h500 + 24'(i), lr, 1'b1);
    lr = ~lr;
    step(1'b0, 1'b0, 24'h0, lr, 1'b1);
    chk("pre_rst_level", LEVEL, 5);
    chk("pre_rst_audio", AUDIO, 24'h501);
    lr = ~lr;
    step(1'b1, 1'b0, 24'h0, lr, 1'b1);
    chk("mid_rst_level", LEVEL, 0);
    chk("mid_rst_audio", AUDIO, 0);
    chk("mid_rst_urun", UNDERRUN_COUNT, 0);
    // leaving reset with LRCLK high gives an immediate (underrun) pop
    step(1'b1, 1'b0, 24'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    chk("post_rst_urun", UNDERRUN_COUNT, 1);
    chk("post_rst_audio", AUDIO, 0);
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
    chk("post_rst_hold", UNDERRUN_COUNT, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
